layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Parametrised N-layer video compositor; sits after the per-object draw_* sprite modules and feeds the XVGA output.
//  Delays hsync/vsync/blank by a configurable pipeline depth, priority-muxes the layer pixels and substitutes a background colour.
//  Also accumulates per-frame layer-overlap (collision) flags, latched once per frame at the vsync edge.
// PARAMETERS
//  NUM_LAYERS  4        number of input layers (2..8); layer 0 = highest priority
//  PIXEL_W     24       bits per pixel (r=[23:16], g=[15:8], b=[7:0] when 24)
//  SYNC_DELAY  6        total timing-signal delay in cycles (>=2); equals sprite latency + 1
//  BG_COLOR    24'h0    colour output where no enabled layer is opaque (PIXEL_W bits)
// PORTS
//  vclock          in   1                   pixel clock (65 MHz XVGA)
//  reset           in   1                   synchronous, active-high
//  hsync           in   1                   XVGA hsync, active low
//  vsync           in   1                   XVGA vsync, active low
//  blank           in   1                   1 = blanking interval
//  layer_pixels    in   NUM_LAYERS*PIXEL_W  layer i at [i*PIXEL_W +: PIXEL_W]; nonzero = opaque
//  layer_en        in   NUM_LAYERS          1 = layer participates (mux and collision)
//  phsync          out  1                   hsync delayed SYNC_DELAY cycles
//  pvsync          out  1                   vsync delayed SYNC_DELAY cycles
//  pblank          out  1                   blank delayed SYNC_DELAY cycles
//  pixel           out  PIXEL_W             composited pixel, aligned with phsync/pvsync/pblank
//  collision_mask  out  NUM_LAYERS          bit i = layer i overlapped another layer in previous frame
//  frame_done      out  1                   1-cycle pulse when collision_mask updates
// BEHAVIOUR
//  - Reset (sync): all delay-line stages hsync/vsync=1, blank=1; pixel=0, phsync=1, pvsync=1, pblank=1,
//    collision_mask=0, frame_done=0, collision accumulator=0. Reset mid-frame discards partial accumulation.
//  - Timing: a shift register of depth SYNC_DELAY per sync/blank signal. layer_pixels present in cycle t
//    correspond to timing inputs from cycle t-(SYNC_DELAY-1); stage SYNC_DELAY-1 (blank_a/vsync_a) is the aligned tap.
//  - Pixel mux (registered, 1 cycle): opaque_i = layer_en[i] & |layer_i. pixel <= lowest-index opaque layer,
//    else BG_COLOR; pixel <= 0 when blank_a=1. Output lands with phsync/pvsync/pblank of the same cycle.
//  - Collision: hit = (blank_a==0) & (popcount(opaque) >= 2). On hit, accum <= accum | opaque.
//    Disabled or transparent layers never set bits.
//  - Frame latch: on vsync_a falling edge (vsync_a==0, previous vsync_a==1): collision_mask <= accum | (hit ? opaque : 0);
//    accum <= 0; frame_done <= 1 for exactly one cycle. Same-cycle hit is folded into the closing frame, not the next.
//  - No latch occurs until the first vsync falling edge after reset; collision_mask holds 0 until then.
//  - layer_en may change any cycle; takes effect on the same cycle's mux/collision evaluation.
// CONFIGURATION
//  - COMPOSITOR_HITCOUNT_EN defined: extra port hit_count out 20 = number of hit pixels in previous frame;
//    internal counter increments per hit cycle, saturates at 20'hFFFFF, latched/cleared with collision_mask
//    (same-cycle hit included), reset to 0.
//  - Not defined: port and counter absent; all other behaviour identical.
// TESTING  (NUM_LAYERS=4, PIXEL_W=24, SYNC_DELAY=6, BG_COLOR=24'h102030)
//  - Toggle hsync/vsync/blank single-cycle pulses -> phsync/pvsync/pblank replicate them exactly 6 cycles later.
//  - Layers {0,FF0000,00FF00,0} all enabled, blank_a=0 -> pixel=FF0000 one cycle later; layer_en=4'b1101 -> 00FF00.
//  - All layers 0, blank_a=0 -> pixel=102030; blank_a=1 with layer0=FFFFFF -> pixel=0.
//  - Layers 1 and 3 opaque for 10 cycles mid-frame, then vsync_a falls -> collision_mask=4'b1010, frame_done 1 cycle,
//    hit_count=10 (macro on); next frame no overlap -> collision_mask=0.
//  - Overlap of layers 0,2 on the exact vsync_a-fall cycle -> included in latched mask 4'b0101; next frame mask=0.
//  - Assert reset mid-frame after overlaps -> all outputs at reset values; next latch reports only post-reset hits.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: N-layer priority compositor with sync/blank delay line and per-frame collision flags.
// Define COMPOSITOR_HITCOUNT_EN to add the saturating per-frame hit_count output.
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int PIXEL_W = 24,
  parameter int SYNC_DELAY = 6,
  parameter logic [PIXEL_W-1:0] BG_COLOR = '0
) (
  input  logic vclock,
  input  logic reset,
  input  logic hsync,
  input  logic vsync,
  input  logic blank,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] layer_pixels,
  input  logic [NUM_LAYERS-1:0] layer_en,
  output logic phsync,
  output logic pvsync,
  output logic pblank,
  output logic [PIXEL_W-1:0] pixel,
  output logic [NUM_LAYERS-1:0] collision_mask,
  output logic frame_done
`ifdef COMPOSITOR_HITCOUNT_EN
  ,
  output logic [19:0] hit_count
`endif
);
  logic [2:0] tl [SYNC_DELAY-1];
  logic hs_a, vs_a, bl_a;
  logic [NUM_LAYERS-1:0] opaque, accum;
  logic [PIXEL_W-1:0] sel;
  logic hit, fall;
  assign {hs_a, vs_a, bl_a} = tl[SYNC_DELAY-2];
  always_comb begin
    opaque = '0;
    sel = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      opaque[i] = layer_en[i] & |layer_pixels[i*PIXEL_W +: PIXEL_W];
      sel = opaque[i] ? layer_pixels[i*PIXEL_W +: PIXEL_W] : sel;
    end
  end
  // clearing the lowest set bit leaves something only when two or more layers are opaque
  assign hit = !bl_a && |(opaque & (opaque - NUM_LAYERS'(1)));
  // pvsync holds last cycle's vs_a, so it doubles as the edge-detect history
  assign fall = !vs_a && pvsync;
  always_ff @(posedge vclock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_DELAY - 1; i++) tl[i] <= 3'b111;
      {phsync, pvsync, pblank} <= 3'b111;
      pixel <= '0;
      collision_mask <= '0;
      frame_done <= 1'b0;
      accum <= '0;
    end else begin
      tl[0] <= {hsync, vsync, blank};
      for (int i = 1; i < SYNC_DELAY - 1; i++) tl[i] <= tl[i-1];
      {phsync, pvsync, pblank} <= {hs_a, vs_a, bl_a};
      pixel <= bl_a ? '0 : sel;
      frame_done <= fall;
      if (fall) collision_mask <= accum | (hit ? opaque : '0);
      accum <= fall ? '0 : hit ? accum | opaque : accum;
    end
  end
`ifdef COMPOSITOR_HITCOUNT_EN
  logic [19:0] hits, hits_n;
  assign hits_n = (hit && !(&hits)) ? hits + 20'd1 : hits;
  always_ff @(posedge vclock) begin
    if (reset) begin
      hits <= '0;
      hit_count <= '0;
    end else begin
      if (fall) hit_count <= hits_n;
      hits <= fall ? '0 : hits_n;
    end
  end
`endif
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed checks of delay alignment, priority mux, collision latching and reset.
module tb_layer_compositor;
  logic vclock = 0, reset = 1, hsync = 1, vsync = 1, blank = 1;
  logic [95:0] layer_pixels = '0;
  logic [3:0] layer_en = 4'hF;
  logic phsync, pvsync, pblank, frame_done;
  logic [23:0] pixel;
  logic [3:0] collision_mask;
`ifdef COMPOSITOR_HITCOUNT_EN
  logic [19:0] hit_count;
`endif
  int checks = 0, failures = 0;

  always #5 vclock = ~vclock;

  layer_compositor #(.NUM_LAYERS(4), .PIXEL_W(24), .SYNC_DELAY(6), .BG_COLOR(24'h102030)) dut (
    .vclock(vclock), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .layer_pixels(layer_pixels), .layer_en(layer_en),
    .phsync(phsync), .pvsync(pvsync), .pblank(pblank), .pixel(pixel),
    .collision_mask(collision_mask), .frame_done(frame_done)
`ifdef COMPOSITOR_HITCOUNT_EN
    , .hit_count(hit_count)
`endif
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge vclock);
      #1;
    end
  endtask

  function automatic logic [95:0] lp(input logic [23:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // vsync_a falls on the final step, where `last` is presented; vsync returns high afterwards
  task automatic frame_close(input logic [95:0] last);
    vsync = 1;
    step(8);
    vsync = 0;
    step(5);
    layer_pixels = last;
    step(1);
    layer_pixels = '0;
    vsync = 1;
  endtask

  task automatic test_reset;
    reset = 1;
    step(2);
    checks++; if (pixel !== 24'h0) begin failures++; $display("FAIL reset_pixel got=%h exp=%h", pixel, 24'h0); end
    checks++; if ({phsync, pvsync, pblank, frame_done} !== 4'b1110) begin failures++; $display("FAIL reset_sync got=%b exp=1110", {phsync, pvsync, pblank, frame_done}); end
    checks++; if (collision_mask !== 4'b0) begin failures++; $display("FAIL reset_mask got=%b exp=0000", collision_mask); end
    reset = 0;
  endtask

  task automatic test_delay;
    hsync = 0; vsync = 0; blank = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 1) begin hsync = 1; vsync = 1; blank = 1; end
      checks++;
      if ({phsync, pvsync, pblank} !== ((k == 6) ? 3'b000 : 3'b111)) begin
        failures++; $display("FAIL delay_k%0d got=%b exp=%b", k, {phsync, pvsync, pblank}, (k == 6) ? 3'b000 : 3'b111);
      end
      checks++;
      if (pixel !== ((k == 6) ? 24'h102030 : 24'h0)) begin
        failures++; $display("FAIL delay_pixel_k%0d got=%h exp=%h", k, pixel, (k == 6) ? 24'h102030 : 24'h0);
      end
    end
  endtask

  task automatic test_mux;
    blank = 0;
    step(8);
    layer_pixels = lp(24'h0, 24'hFF0000, 24'h00FF00, 24'h0); layer_en = 4'hF;
    step(1);
    checks++; if (pixel !== 24'hFF0000) begin failures++; $display("FAIL mux_prio got=%h exp=ff0000", pixel); end
    layer_en = 4'b1101;
    step(1);
    checks++; if (pixel !== 24'h00FF00) begin failures++; $display("FAIL mux_en got=%h exp=00ff00", pixel); end
    layer_pixels = lp(24'hFFFFFF, 24'h0, 24'h00FF00, 24'h0); layer_en = 4'b1110;
    step(1);
    checks++; if (pixel !== 24'h00FF00) begin failures++; $display("FAIL mux_en0 got=%h exp=00ff00", pixel); end
    layer_pixels = '0; layer_en = 4'hF;
    step(1);
    checks++; if (pixel !== 24'h102030) begin failures++; $display("FAIL mux_bg got=%h exp=102030", pixel); end
    layer_pixels = lp(24'hFFFFFF, 24'h0, 24'h0, 24'h0);
    blank = 1;
    step(5);
    checks++; if (pixel !== 24'hFFFFFF) begin failures++; $display("FAIL mux_preblank got=%h exp=ffffff", pixel); end
    step(1);
    checks++; if ({pixel, pblank} !== {24'h0, 1'b1}) begin failures++; $display("FAIL mux_blank got=%h/%b exp=000000/1", pixel, pblank); end
    layer_pixels = '0;
  endtask

  task automatic test_collision;
    reset = 1; step(2); reset = 0;
    blank = 0; vsync = 1;
    step(8);
    layer_pixels = lp(24'h0, 24'h11, 24'h0, 24'h33);
    step(10);
    layer_pixels = '0;
    frame_close('0);
    checks++; if ({collision_mask, frame_done} !== 5'b10101) begin failures++; $display("FAIL coll_mask got=%b/%b exp=1010/1", collision_mask, frame_done); end
`ifdef COMPOSITOR_HITCOUNT_EN
    checks++; if (hit_count !== 20'd10) begin failures++; $display("FAIL coll_hits got=%0d exp=10", hit_count); end
`endif
    step(1);
    checks++; if ({collision_mask, frame_done} !== 5'b10100) begin failures++; $display("FAIL coll_pulse got=%b/%b exp=1010/0", collision_mask, frame_done); end
    frame_close('0);
    checks++; if ({collision_mask, frame_done} !== 5'b00001) begin failures++; $display("FAIL coll_clear got=%b/%b exp=0000/1", collision_mask, frame_done); end
  endtask

  task automatic test_fold;
    frame_close(lp(24'h44, 24'h0, 24'h22, 24'h0));
    checks++; if (collision_mask !== 4'b0101) begin failures++; $display("FAIL fold_mask got=%b exp=0101", collision_mask); end
`ifdef COMPOSITOR_HITCOUNT_EN
    checks++; if (hit_count !== 20'd1) begin failures++; $display("FAIL fold_hits got=%0d exp=1", hit_count); end
`endif
    frame_close('0);
    checks++; if (collision_mask !== 4'b0) begin failures++; $display("FAIL fold_next got=%b exp=0000", collision_mask); end
  endtask

  task automatic test_enable_blank;
    layer_pixels = lp(24'h1, 24'h2, 24'h0, 24'h3); layer_en = 4'b1101;
    step(3);
    layer_pixels = '0; layer_en = 4'hF;
    blank = 1;
    step(8);
    layer_pixels = lp(24'h5, 24'h5, 24'h5, 24'h5);
    step(4);
    layer_pixels = '0;
    blank = 0;
    step(8);
    frame_close('0);
    checks++; if (collision_mask !== 4'b1001) begin failures++; $display("FAIL en_mask got=%b exp=1001", collision_mask); end
`ifdef COMPOSITOR_HITCOUNT_EN
    checks++; if (hit_count !== 20'd3) begin failures++; $display("FAIL en_hits got=%0d exp=3", hit_count); end
`endif
  endtask

  task automatic test_reset_mid;
    layer_pixels = lp(24'h1, 24'h1, 24'h0, 24'h0);
    step(5);
    reset = 1;
    step(2);
    checks++; if ({pixel, phsync, pvsync, pblank, frame_done} !== {24'h0, 4'b1110}) begin failures++; $display("FAIL rmid_outs got=%h/%b exp=000000/1110", pixel, {phsync, pvsync, pblank, frame_done}); end
    checks++; if (collision_mask !== 4'b0) begin failures++; $display("FAIL rmid_mask got=%b exp=0000", collision_mask); end
    reset = 0;
    layer_pixels = '0;
    step(8);
    layer_pixels = lp(24'h0, 24'h0, 24'h7, 24'h7);
    step(4);
    layer_pixels = '0;
    frame_close('0);
    checks++; if (collision_mask !== 4'b1100) begin failures++; $display("FAIL rmid_latch got=%b exp=1100", collision_mask); end
`ifdef COMPOSITOR_HITCOUNT_EN
    checks++; if (hit_count !== 20'd4) begin failures++; $display("FAIL rmid_hits got=%0d exp=4", hit_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_delay();
    test_mux();
    test_collision();
    test_fold();
    test_enable_blank();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
